// File: rtl/panel_cmd_responder_pkg.sv
// PDP-8 front-panel responder: shared word type,
// FSM states and panel command encodings.
package panel_cmd_responder_pkg;

  typedef logic [11:0] word;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    EXEC_PC,
    MEM_WR,
    MEM_RD,
    RELEASE
  } panel_state_t;

  typedef enum logic [1:0] {
    CMD_LOAD_PC,
    CMD_DEPOSIT,
    CMD_EXAMINE
  } panel_cmd_t;

endpackage

// File: rtl/panel_cmd_responder_if.sv
// Memory-controller side of the front panel:
// request/done handshake with address and data.
interface panel_cmd_responder_if #(
    parameter int AW = 12
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic [AW-1:0] mem_rdata;
    logic          mem_done;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/panel_cmd_responder_hold_filter.sv
// Minimum-hold filter for one panel button: accepted pulses
// in the cycle where the button completes HOLD_CYCLES highs.
module panel_hold_filter #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clear,
    output logic accepted
);
    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (btn && !accepted) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign accepted = btn && !clear && (cnt_q == LAST);
endmodule

// File: rtl/panel_cmd_responder.sv
// Front-panel command responder: turns each filtered button
// press into one PC load, memory deposit or memory examine.
module panel_cmd_responder
    import panel_cmd_responder_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int AW          = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [AW-1:0]         sw,
    input  logic                  btn_load_pc,
    input  logic                  btn_deposit,
    input  logic                  btn_examine,
    output logic                  pc_load,
    output logic [AW-1:0]         pc_value,
    output logic [AW-1:0]         display,
    output logic                  busy,
    panel_cmd_responder_if.master mem
);
    localparam logic [AW-1:0] ONE = AW'(1);

    panel_state_t  state_q, state_d;
    panel_cmd_t    cmd_q, cmd_sel;
    logic [AW-1:0] addr_q, cmd_data, pc_q, disp_q;
    logic          any_btn, btn_cur, accepted;
    logic          hold_clr, mem_st, take;

    assign any_btn  = btn_load_pc | btn_deposit | btn_examine;
    assign hold_clr = (state_q != HOLD);
    assign mem_st   = (state_q == MEM_WR) || (state_q == MEM_RD);
    assign take     = (state_q == HOLD) && accepted && !run;

    always_comb begin
        cmd_sel = CMD_EXAMINE;
        if (btn_load_pc)      cmd_sel = CMD_LOAD_PC;
        else if (btn_deposit) cmd_sel = CMD_DEPOSIT;
    end

    // Only the button that opened the press is tracked in HOLD.
    always_comb begin
        btn_cur = btn_examine;
        if (cmd_q == CMD_LOAD_PC)      btn_cur = btn_load_pc;
        else if (cmd_q == CMD_DEPOSIT) btn_cur = btn_deposit;
    end

    panel_hold_filter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn_cur),
        .clear   (hold_clr),
        .accepted(accepted)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!run && any_btn) state_d = HOLD;
            end
            HOLD: begin
                if (run || !btn_cur) begin
                    state_d = IDLE;
                end else if (accepted) begin
                    unique case (cmd_q)
                        CMD_LOAD_PC: state_d = EXEC_PC;
                        CMD_DEPOSIT: state_d = MEM_WR;
                        default:     state_d = MEM_RD;
                    endcase
                end
            end
            EXEC_PC: state_d = run ? IDLE : RELEASE;
            MEM_WR, MEM_RD: begin
                if (mem.mem_done) state_d = run ? IDLE : RELEASE;
            end
            RELEASE: begin
                if (run || !any_btn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_LOAD_PC;
            cmd_data <= '0;
            addr_q   <= '0;
            pc_q     <= '0;
            disp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == HOLD) cmd_q <= cmd_sel;
            // PC value is loaded at acceptance so it is valid with the strobe.
            if (take) begin
                cmd_data <= sw;
                if (cmd_q == CMD_LOAD_PC) begin
                    pc_q   <= sw;
                    addr_q <= sw;
                end
            end
            if (mem_st && mem.mem_done) begin
                disp_q <= (state_q == MEM_WR) ? cmd_data : mem.mem_rdata;
                addr_q <= addr_q + ONE;
            end
        end
    end

    assign pc_load       = (state_q == EXEC_PC);
    assign pc_value      = pc_q;
    assign display       = disp_q;
    assign busy          = (state_q != IDLE);
    assign mem.mem_req   = mem_st;
    assign mem.mem_we    = (state_q == MEM_WR);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = cmd_data;
endmodule

// File: tb/tb_panel_cmd_responder.sv
// Scoreboard bench for panel_cmd_responder: directed presses,
// behavioural memory and a negedge monitor.
module tb_panel_cmd_responder;
    import panel_cmd_responder_pkg::*;

    localparam int HOLD = 8;

    typedef struct {
        logic [1:0] kind;
        word        addr;
        word        data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    word  sw  = '0;
    logic btn_load_pc = 1'b0;
    logic btn_deposit = 1'b0;
    logic btn_examine = 1'b0;
    logic pc_load, busy;
    word  pc_value, display;

    panel_cmd_responder_if #(.AW(12)) m ();

    panel_cmd_responder #(
        .HOLD_CYCLES(HOLD),
        .AW         (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .sw         (sw),
        .btn_load_pc(btn_load_pc),
        .btn_deposit(btn_deposit),
        .btn_examine(btn_examine),
        .pc_load    (pc_load),
        .pc_value   (pc_value),
        .display    (display),
        .busy       (busy),
        .mem        (m)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic pop_check(input logic [1:0] kind, input word addr,
                             input word data);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d addr %0o, none expected",
                     kind, addr);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_addr", 32'(addr), 32'(e.addr));
            if (e.kind == 2'd1) check("event_wdata", 32'(data), 32'(e.data));
        end
    endtask

    // Behavioural memory controller
    word  mem_arr [4096];
    int   done_delay = 0;
    int   wait_cnt   = 0;
    logic inject_tgl = 1'b0;
    logic inj_last   = 1'b0;

    initial begin
        m.mem_done  = 1'b0;
        m.mem_rdata = '0;
    end

    always @(negedge clk) begin
        m.mem_done = 1'b0;
        if (inject_tgl != inj_last) begin
            inj_last   = inject_tgl;
            m.mem_done = 1'b1;
        end else if (m.mem_req) begin
            if (wait_cnt >= done_delay) begin
                m.mem_done  = 1'b1;
                m.mem_rdata = mem_arr[m.mem_addr];
                if (m.mem_we) mem_arr[m.mem_addr] = m.mem_wdata;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor
    logic prev_pc  = 1'b0;
    logic prev_req = 1'b0;
    logic [24:0] cap;

    always @(negedge clk) begin
        if (!rst) begin
            if (pc_load) begin
                check("pc_load_width", 32'(prev_pc), 32'd0);
                pop_check(2'd0, pc_value, '0);
            end
            if (m.mem_req && !prev_req) begin
                cap = {m.mem_we, m.mem_addr, m.mem_wdata};
                pop_check(m.mem_we ? 2'd1 : 2'd2, m.mem_addr, m.mem_wdata);
            end else if (m.mem_req) begin
                check("req_stable", 32'({m.mem_we, m.mem_addr, m.mem_wdata}),
                      32'(cap));
            end
        end
        prev_pc  = pc_load;
        prev_req = m.mem_req;
    end

    task automatic expect_ev(input logic [1:0] k, input word a, input word d);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [2:0] b, input int n, input word v);
        sw = v;
        {btn_load_pc, btn_deposit, btn_examine} = b;
        repeat (n) @(negedge clk);
        {btn_load_pc, btn_deposit, btn_examine} = 3'b000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_arr[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_pc_load", 32'(pc_load), 0);
        check("rst_pc_value", 32'(pc_value), 0);
        check("rst_display", 32'(display), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_req", 32'(m.mem_req), 0);
        rst = 1'b0;
        @(negedge clk);

        // Load PC
        expect_ev(2'd0, 12'o0200, '0);
        press(3'b100, 10, 12'o0200);
        wait_idle();
        check("lpc_addr_q", 32'(dut.addr_q), 32'o0200);

        // Two deposits with auto-increment
        expect_ev(2'd1, 12'o0200, 12'o7402);
        press(3'b010, 10, 12'o7402);
        wait_idle();
        expect_ev(2'd1, 12'o0201, 12'o1234);
        press(3'b010, 10, 12'o1234);
        wait_idle();
        check("dep_display", 32'(display), 32'o1234);
        check("dep_addr_q", 32'(dut.addr_q), 32'o0202);
        check("dep_mem0200", 32'(mem_arr[12'o0200]), 32'o7402);

        // Short glitch, then long hold
        press(3'b010, HOLD - 1, 12'o0666);
        @(negedge clk);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_addr_q", 32'(dut.addr_q), 32'o0202);
        expect_ev(2'd1, 12'o0202, 12'o0055);
        press(3'b010, 50, 12'o0055);
        wait_idle();
        check("long_addr_q", 32'(dut.addr_q), 32'o0203);

        // Examine at top of memory with slow done
        mem_arr[12'o7777] = 12'o4321;
        expect_ev(2'd0, 12'o7777, '0);
        press(3'b100, 10, 12'o7777);
        wait_idle();
        done_delay = 5;
        expect_ev(2'd2, 12'o7777, '0);
        press(3'b001, 10, 12'o0000);
        wait_idle();
        done_delay = 0;
        check("exam_display", 32'(display), 32'o4321);
        check("exam_addr_wrap", 32'(dut.addr_q), 32'o0000);

        // Run blocks buttons
        run = 1'b1;
        press(3'b010, 10, 12'o1111);
        check("run_busy", 32'(busy), 0);
        run = 1'b0;
        repeat (2) @(negedge clk);

        // Priority: load_pc beats deposit
        expect_ev(2'd0, 12'o0100, '0);
        press(3'b110, 10, 12'o0100);
        wait_idle();
        check("prio_addr_q", 32'(dut.addr_q), 32'o0100);
        check("prio_display", 32'(display), 32'o4321);

        // Reset in the middle of a write
        done_delay = 1000;
        expect_ev(2'd1, 12'o0100, 12'o0777);
        press(3'b010, 10, 12'o0777);
        check("midwr_req", 32'(m.mem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwr_mem_req", 32'(m.mem_req), 0);
        check("rstwr_mem_we", 32'(m.mem_we), 0);
        check("rstwr_wdata", 32'(m.mem_wdata), 0);
        check("rstwr_busy", 32'(busy), 0);
        check("rstwr_pc_value", 32'(pc_value), 0);
        check("rstwr_display", 32'(display), 0);
        rst = 1'b0;
        done_delay = 0;
        inject_tgl = ~inject_tgl;
        repeat (3) @(negedge clk);
        check("late_done_addr", 32'(dut.addr_q), 0);
        check("late_done_disp", 32'(display), 0);
        check("late_done_busy", 32'(busy), 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/panel_cmd_responder.md
# panel_cmd_responder

Synthesizable responder for the PDP-8 front-panel command protocol. It samples the 12-bit switch bank and the Load-PC, Deposit and Examine buttons, filters the buttons against a minimum hold time, and turns each accepted press into exactly one action: a PC load, a memory write or a memory read. It sits between the panel I/O (or the emulation transactor driving it) and the memory controller / CPU PC-load path, and is active only while the machine is stopped.

## Interface
- `HOLD_CYCLES`, 8: consecutive high cycles a button needs before its command is accepted (range 1–255).
- `AW`, 12: address and data width (PDP-8 word).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `run`  in  1  CPU running; while high, all buttons are ignored.
- `sw`  in  AW  switch register.
- `btn_load_pc`, `btn_deposit`, `btn_examine`  in  1 each  level buttons.
- `pc_load`  out  1  one-cycle strobe that loads `pc_value` into the CPU PC.
- `pc_value`  out  AW  value to load into the PC.
- `mem_req`  out  1  memory request, held high until `mem_done`.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  AW  write data.
- `mem_rdata`  in  AW  read data, valid in the cycle `mem_done` is high.
- `mem_done`  in  1  one-cycle completion from the memory controller.
- `display`  out  AW  last deposited or examined word (LED bank).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Internal address register `addr_q` (AW bits) is the panel's current address. `mem_addr` is `addr_q`.
- States: IDLE, HOLD, EXEC_PC, MEM_WR, MEM_RD, RELEASE.
- **IDLE → HOLD:** any button is high and `run` is low. The command is fixed at this point by priority: load_pc > deposit > examine. The hold counter is cleared.
- **In HOLD:**
  - The counter increments each cycle the chosen button is still high.
  - If the button drops before the count is reached, return to IDLE; no action is taken.
  - When the count reaches `HOLD_CYCLES`, `sw` is latched into `cmd_data` and the FSM moves to EXEC_PC, MEM_WR or MEM_RD according to the command.
- **EXEC_PC:** `addr_q` ← `cmd_data`, `pc_value` ← `cmd_data`, and `pc_load` is pulsed for one cycle. Go to RELEASE.
- **MEM_WR:**
  - `mem_req` = 1, `mem_we` = 1, `mem_wdata` = `cmd_data`.
  - On `mem_done`: `display` ← `cmd_data` and `addr_q` ← `addr_q` + 1. Go to RELEASE.
- **MEM_RD:**
  - `mem_req` = 1, `mem_we` = 0.
  - On `mem_done`: `display` ← `mem_rdata` and `addr_q` ← `addr_q` + 1. Go to RELEASE.
- **RELEASE:** wait until all three buttons are low in the same cycle, then go to IDLE. This guarantees one action per press.
- **Address arithmetic:** modulo 2^AW. Incrementing from 7777₈ gives 0000₈, with no flag raised.
- **run:**
  - Rising while in IDLE, HOLD or RELEASE: go to IDLE immediately and clear the counter.
  - During MEM_WR/MEM_RD the transfer completes normally first, then the FSM goes to IDLE.
  - During EXEC_PC the single-cycle PC strobe completes, then the FSM goes to IDLE.
- **Simultaneous buttons:** only the highest-priority button is tracked. Other buttons being high, or going high, during HOLD do not matter.

## Timing
- **Reset values:** state IDLE, `addr_q` = 0, `pc_value` = 0, `display` = 0. `pc_load`, `mem_req`, `mem_we`, `busy` = 0. `mem_wdata` = 0.
- **Reset during MEM_WR/MEM_RD:** `mem_req` is low from the cycle after the reset edge. A `mem_done` arriving after reset is ignored.
- **Accept latency:** a button rising at edge N is accepted at edge N+HOLD_CYCLES. The action state is entered at that same edge.
- **pc_load:** high for exactly one cycle, in the cycle after acceptance.
- **mem_req:**
  - Rises in the cycle after acceptance.
  - `mem_addr`, `mem_we` and `mem_wdata` are stable for the whole time `mem_req` is high.
  - `mem_req` falls on the edge where `mem_done` = 1 is sampled.
  - `mem_done` while `mem_req` is low is ignored.
- **display / addr_q:** updated on the `mem_done` edge and visible in the next cycle.
- **Throughput:** at least HOLD_CYCLES + 2 cycles between actions, plus the time to release the button.

## Structure
- Add to `CPU_Definitions.pkg`:
  - `panel_state_t` enum (IDLE, HOLD, EXEC_PC, MEM_WR, MEM_RD, RELEASE).
  - `panel_cmd_t` enum (CMD_LOAD_PC, CMD_DEPOSIT, CMD_EXAMINE).
- Reuse the existing `word` typedef for AW = 12 signals.
- One sub-module: `panel_hold_filter`. It holds the counter plus a button-stable comparator, with inputs `btn` and `clear` and output `accepted`.

## Test plan
- **Load PC:** `sw` = 0200₈, `btn_load_pc` high for 10 cycles → exactly one `pc_load` with `pc_value` = 0200₈, `addr_q` = 0200₈, no `mem_req`.
- **Deposit with increment:** Load PC 0200₈, then deposit 7402₈ and 1234₈ → writes to (0200₈, 7402₈) and (0201₈, 1234₈), `display` = 1234₈, `addr_q` = 0202₈.
- **Short glitch:** `btn_deposit` high for HOLD_CYCLES−1 cycles → no `mem_req`, state back to IDLE. A button held for 50 cycles → exactly one write.
- **Examine with wrap:** Load PC 7777₈, memory holds 4321₈ there, examine → read at 7777₈, `display` = 4321₈, `addr_q` = 0000₈. Delaying `mem_done` by 5 cycles keeps `mem_req`/`mem_addr` stable throughout.
- **Run and priority:** with `run` = 1, a deposit press produces no activity. With `run` = 0 and load_pc and deposit pressed together → only `pc_load` fires.
- **Reset mid-write:** `rst` while `mem_req` is high → `mem_req` = 0 in the next cycle, all outputs at reset values, a late `mem_done` is ignored.
